// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_addsub_cell.sv
// One-bit add/subtract cell; in subtract mode cin/cout carry a borrow.
module full_addsub_cell
  import addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic mode,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (mode == MODE_SUB) ? ((~a & b) | (cin & ~(a ^ b)))
                                   : ((a & b)  | (cin & (a ^ b)));

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, start/busy/done handshake,
// result and flags held from done until the next accepted start.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] RESULT,
  output logic             COUT,
  output logic             OVF,
  output logic             ZERO
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  function automatic logic ovf_flag(input logic m, input logic a, input logic b,
                                    input logic s);
    if (m == MODE_SUB) return (a != b) && (s != a);
    return (a == b) && (s != a);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, result_q;
  logic [CW-1:0]    cnt_q;
  logic             mode_q, c_q, amsb_q, bmsb_q;
  logic             cout_q, ovf_q, zero_q;
  logic             accept, step, last;

  logic [DIGIT:0]   carry;
  logic [DIGIT-1:0] dsum;
  logic [WIDTH-1:0] res_next;

  // Carry/borrow ripples LSB to MSB within a digit; the chain end feeds c_q.
  assign carry[0] = c_q;
  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    full_addsub_cell u_cell (
      .a    (a_q[i]),
      .b    (b_q[i]),
      .cin  (carry[i]),
      .mode (mode_q),
      .s    (dsum[i]),
      .cout (carry[i+1])
    );
  end

  assign res_next = (res_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          last    = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      mode_q   <= MODE_ADD;
      c_q      <= 1'b0;
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q    <= A;
        b_q    <= B;
        mode_q <= mode;
        amsb_q <= A[WIDTH-1];
        bmsb_q <= B[WIDTH-1];
        res_q  <= '0;
        c_q    <= 1'b0;
        cnt_q  <= '0;
      end else if (step) begin
        a_q   <= a_q >> DIGIT;
        b_q   <= b_q >> DIGIT;
        res_q <= res_next;
        c_q   <= carry[DIGIT];
        if (!last) cnt_q <= cnt_q + CW'(1);
      end
      // Operand MSBs were shifted out long ago, so flags use the latched copies.
      if (last) begin
        result_q <= res_next;
        cout_q   <= carry[DIGIT];
        ovf_q    <= ovf_flag(mode_q, amsb_q, bmsb_q, res_next[WIDTH-1]);
        zero_q   <= (res_next == '0);
      end
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign RESULT = result_q;
  assign COUT   = cout_q;
  assign OVF    = ovf_q;
  assign ZERO   = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and sweep bench for serial_addsub with DIGIT=1 and DIGIT=4 instances.
module tb_serial_addsub;
  import addsub_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start8, mode8, busy8, done8, cout8, ovf8, zero8;
  logic [7:0] a8, b8, res8;
  logic       start4, mode4, busy4, done4, cout4, ovf4, zero4;
  logic [7:0] a4, b4, res4;

  int checks   = 0;
  int failures = 0;
  logic [10:0] q8[$];
  logic [10:0] q4[$];

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .mode(mode8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .RESULT(res8), .COUT(cout8), .OVF(ovf8), .ZERO(zero8)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .mode(mode4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .RESULT(res4), .COUT(cout4), .OVF(ovf4), .ZERO(zero4)
  );

  // Packed as {ZERO, OVF, COUT, RESULT}.
  function automatic logic [10:0] model(input logic m, input logic [7:0] a, input logic [7:0] b);
    int         sa, sb, r;
    logic [8:0] w;
    logic       ov;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (m == MODE_SUB) begin
      w = {1'b0, a} - {1'b0, b};
      r = sa - sb;
    end else begin
      w = {1'b0, a} + {1'b0, b};
      r = sa + sb;
    end
    ov = (r > 127) || (r < -128);
    return {(w[7:0] == 8'h00), ov, w[8], w[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op8(input logic m, input logic [7:0] a, input logic [7:0] b);
    mode8 = m; a8 = a; b8 = b; start8 = 1'b1;
    q8.push_back(model(m, a, b));
  endtask

  task automatic start_op4(input logic m, input logic [7:0] a, input logic [7:0] b);
    mode4 = m; a4 = a; b4 = b; start4 = 1'b1;
    q4.push_back(model(m, a, b));
  endtask

  // Waits for done on the DIGIT=1 instance; optionally re-pulses start with new
  // operands at cycle glitch_cyc while the operation is running.
  task automatic wait_done8(input int glitch_cyc, output int lat, output int busyc);
    lat = -1;
    busyc = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) start8 = 1'b0;
      if (cyc == glitch_cyc) begin
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; mode8 = MODE_ADD;
      end else if (glitch_cyc > 0 && cyc == glitch_cyc + 1) begin
        start8 = 1'b0;
      end
      if (busy8) busyc++;
      if (done8) begin
        lat = cyc;
        return;
      end
    end
  endtask

  task automatic wait_done4(output int lat);
    lat = -1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) start4 = 1'b0;
      if (done4) begin
        lat = cyc;
        return;
      end
    end
  endtask

  task automatic check_res8(input string tag);
    logic [10:0] exp;
    if (q8.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = q8.pop_front();
      chk(tag, {21'd0, zero8, ovf8, cout8, res8}, {21'd0, exp});
    end
  endtask

  task automatic check_res4(input string tag);
    logic [10:0] exp;
    if (q4.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = q4.pop_front();
      chk(tag, {21'd0, zero4, ovf4, cout4, res4}, {21'd0, exp});
    end
  endtask

  initial begin
    int   lat, busyc;
    logic seen;

    reset = 1'b1;
    start8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; mode4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_outs8", {18'd0, busy8, done8, zero8, ovf8, cout8, res8}, 32'd0);
    chk("reset_outs4", {18'd0, busy4, done4, zero4, ovf4, cout4, res4}, 32'd0);

    // sub 5-3: latency, busy length, held result
    start_op8(MODE_SUB, 8'h05, 8'h03);
    wait_done8(0, lat, busyc);
    chk("sub_5_3_latency", lat, 32'd9);
    chk("sub_5_3_busy", busyc, 32'd8);
    check_res8("sub_5_3");
    chk("sub_5_3_val", {24'd0, res8}, 32'h02);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done8}, 32'd0);
    chk("result_held", {24'd0, res8}, 32'h02);

    start_op8(MODE_SUB, 8'h03, 8'h05);
    wait_done8(0, lat, busyc);
    check_res8("sub_3_5");
    start_op8(MODE_SUB, 8'h80, 8'h01);
    wait_done8(0, lat, busyc);
    check_res8("sub_80_01");
    start_op8(MODE_ADD, 8'hFF, 8'h01);
    wait_done8(0, lat, busyc);
    check_res8("add_ff_01");
    chk("add_ff_01_zero", {31'd0, zero8}, 32'd1);
    start_op8(MODE_ADD, 8'h7F, 8'h01);
    wait_done8(0, lat, busyc);
    check_res8("add_7f_01");
    chk("add_7f_01_ovf", {31'd0, ovf8}, 32'd1);

    // start re-pulsed mid-run with new operands is ignored
    start_op8(MODE_SUB, 8'h10, 8'h01);
    wait_done8(3, lat, busyc);
    chk("repulse_latency", lat, 32'd9);
    check_res8("repulse_sub_10_01");
    chk("repulse_val", {24'd0, res8}, 32'h0F);

    // start held in DONE: back-to-back operation
    start_op8(MODE_ADD, 8'h01, 8'h02);
    wait_done8(0, lat, busyc);
    chk("b2b_latency", lat, 32'd9);
    check_res8("b2b_add_1_2");

    // reset during 4th RUN cycle
    @(posedge clk); #1;
    mode8 = MODE_SUB; a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_mid_busy_before", {31'd0, busy8}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_outs", {18'd0, busy8, done8, zero8, ovf8, cout8, res8}, 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) seen = 1'b1;
    end
    chk("rst_mid_no_done", {31'd0, seen}, 32'd0);

    // reset and start together: reset wins
    reset = 1'b1; start8 = 1'b1; a8 = 8'h33; b8 = 8'h11;
    @(posedge clk); #1;
    reset = 1'b0; start8 = 1'b0;
    @(posedge clk); #1;
    chk("rst_start_busy", {31'd0, busy8}, 32'd0);

    start_op8(MODE_ADD, 8'h12, 8'h34);
    wait_done8(0, lat, busyc);
    chk("after_rst_latency", lat, 32'd9);
    check_res8("after_rst_add");

    // DIGIT=4 instance
    start_op4(MODE_SUB, 8'h00, 8'h01);
    wait_done4(lat);
    chk("d4_latency", lat, 32'd3);
    check_res4("d4_sub_0_1");
    chk("d4_sub_0_1_val", {24'd0, res4}, 32'hFF);

    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 256; a++) begin
        for (int bi = 0; bi < 7; bi++) begin
          start_op4(m[0], a[7:0], 8'(bi * 37 + (a % 3)));
          wait_done4(lat);
          check_res4("d4_sweep");
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
